// File: rtl/muldiv_sched.sv
// HI/LO hazard scoreboard and divider handshake sequencer for the execute stage.
// Tracks outstanding HI/LO writers and drives one divide at a time through an external divider.
module muldiv_sched (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   output logic        div_s_valid,
   input  logic        div_s_ready,
   output logic        div_signed,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic        div_p_valid,
   output logic        div_done,
   input  logic        wb_hilo_commit,
   input  logic        flush,
   output logic [1:0]  hilo_pending,
   output logic        busy
);

   // state | meaning
   // IDLE  | no divide in flight, new ops may be accepted
   // SEND  | operands offered to divider, waiting for div_s_ready
   // WAIT  | divider running, div_p_valid returns the result
   // DRAIN | cancelled divide still running, its result is discarded
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  pending_q, pending_d;
   logic        signed_q, signed_d;
   logic [31:0] dividend_q, dividend_d;
   logic [31:0] divisor_q, divisor_d;

   logic is_div;
   logic is_reader;
   logic accept;

   assign is_div    = (req_op[2:1] == 2'b01);
   assign is_reader = (req_op[2:1] == 2'b10);

   // Readers must see every older HI/LO write retired; writers only need a free slot.
   always_comb begin
      req_ready = 1'b0;
      if (!flush && state_q == ST_IDLE) begin
         if (is_reader) req_ready = (pending_q == 2'd0);
         else           req_ready = (pending_q != 2'd3);
      end
   end

   assign accept = req_valid && req_ready;

   always_comb begin
      state_d     = state_q;
      signed_d    = signed_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      div_s_valid = 1'b0;
      div_done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && is_div) begin
               dividend_d = req_a;
               divisor_d  = req_b;
               signed_d   = (req_op == 3'b010);
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            div_s_valid = 1'b1;
            if (flush)            state_d = div_s_ready ? ST_DRAIN : ST_IDLE;
            else if (div_s_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (flush) begin
               state_d = div_p_valid ? ST_IDLE : ST_DRAIN;
            end else if (div_p_valid) begin
               div_done = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (div_p_valid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pending_d = pending_q;
      if (flush) begin
         pending_d = 2'd0;
      end else if (accept && !is_reader) begin
         if (!wb_hilo_commit) pending_d = pending_q + 2'd1;
      end else if (wb_hilo_commit && pending_q != 2'd0) begin
         pending_d = pending_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pending_q  <= 2'd0;
         signed_q   <= 1'b0;
         dividend_q <= 32'd0;
         divisor_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         signed_q   <= signed_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
      end
   end

   assign div_signed   = signed_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   assign hilo_pending = pending_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: divider handshakes go through a scoreboard,
// HI/LO counter and ready behaviour are checked inline.
module tb_muldiv_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        req_ready;
   logic        div_s_valid, div_s_ready;
   logic        div_signed;
   logic [31:0] div_dividend, div_divisor;
   logic        div_p_valid, div_done;
   logic        wb_hilo_commit, flush;
   logic [1:0]  hilo_pending;
   logic        busy;

   localparam logic [2:0] OP_MULT = 3'b000, OP_DIV = 3'b010, OP_DIVU = 3'b011,
                          OP_MFHI = 3'b100, OP_MTHI = 3'b110, OP_MTLO = 3'b111;

   int total = 0;
   int bad   = 0;

   logic [64:0] exp_send[$];
   logic [31:0] exp_done[$];

   muldiv_sched dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .div_s_valid(div_s_valid), .div_s_ready(div_s_ready),
      .div_signed(div_signed), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_p_valid(div_p_valid), .div_done(div_done),
      .wb_hilo_commit(wb_hilo_commit), .flush(flush),
      .hilo_pending(hilo_pending), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: looks just before each rising edge, after stimulus has settled.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!reset && div_s_valid) begin
            total++;
            if (exp_send.size() == 0) begin
               bad++;
               $display("FAIL send_unexpected: got dividend %0h with no op queued", div_dividend);
            end else if ({div_signed, div_dividend, div_divisor} !== exp_send[0]) begin
               bad++;
               $display("FAIL send_operands: got %0h expected %0h",
                        {div_signed, div_dividend, div_divisor}, exp_send[0]);
            end
            if (div_s_ready && exp_send.size() != 0) void'(exp_send.pop_front());
         end
         if (div_done) begin
            total++;
            if (exp_done.size() == 0) begin
               bad++;
               $display("FAIL done_unexpected: got div_done=1 expected 0");
            end else begin
               if (div_dividend !== exp_done[0]) begin
                  bad++;
                  $display("FAIL done_operand: got %0h expected %0h", div_dividend, exp_done[0]);
               end
               void'(exp_done.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      req_valid = 1'b0; div_s_ready = 1'b0; div_p_valid = 1'b0;
      wb_hilo_commit = 1'b0; flush = 1'b0; reset = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
      div_s_ready = 1'b0; div_p_valid = 1'b0; wb_hilo_commit = 1'b0; flush = 1'b0;
      @(negedge clk); @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_pending", hilo_pending, 0);
      check("rst_s_valid", div_s_valid, 0);
      check("rst_operands", {div_signed, div_dividend, div_divisor}, 0);

      // Signed divide with a stalled divider input and a slow result.
      step(); issue(OP_DIV, 32'd100, 32'd7); #1;
      check("div_ready", req_ready, 1);
      exp_send.push_back({1'b1, 32'd100, 32'd7});
      exp_done.push_back(32'd100);
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         check("send_hold_valid", div_s_valid, 1);
         check("send_busy_ready", {busy, req_ready}, 2'b10);
      end
      step(); div_s_ready = 1'b1; #1;
      check("send_last_valid", div_s_valid, 1);
      for (int i = 0; i < 4; i++) begin
         step(); #1;
         check("wait_no_valid", {div_s_valid, div_done}, 2'b00);
      end
      step(); div_p_valid = 1'b1; #1;
      check("wait_done", div_done, 1);
      step(); div_p_valid = 1'b1; #1;
      check("idle_after_div", {busy, div_done}, 2'b00);
      check("pending_after_div", hilo_pending, 1);
      step(); wb_hilo_commit = 1'b1;
      step(); #1;
      check("pending_cleared", hilo_pending, 0);

      // Writer counter saturation and simultaneous accept/commit.
      step(); issue(OP_MULT, 32'd3, 32'd4);
      step(); issue(OP_MULT, 32'd5, 32'd6); #1;
      check("mult_pend1", hilo_pending, 1);
      step(); issue(OP_MULT, 32'd7, 32'd8); #1;
      check("mult_pend2", hilo_pending, 2);
      step(); issue(OP_MTLO, 32'd9, 32'd0); #1;
      check("mult_pend3", hilo_pending, 3);
      check("mtlo_full_ready", req_ready, 0);
      step(); wb_hilo_commit = 1'b1; #1;
      check("commit_pend3", hilo_pending, 3);
      step(); wb_hilo_commit = 1'b1; issue(OP_MTLO, 32'd9, 32'd0); #1;
      check("commit_pend2", hilo_pending, 2);
      check("mtlo_ready", req_ready, 1);
      step(); #1;
      check("accept_commit_hold", hilo_pending, 2);
      step(); wb_hilo_commit = 1'b1;
      step(); wb_hilo_commit = 1'b1;
      step(); wb_hilo_commit = 1'b1; #1;
      check("drop_to0_with_commit", hilo_pending, 0);
      step(); #1;
      check("commit_at_zero", hilo_pending, 0);

      // Reader waits for all older writers to retire.
      step(); issue(OP_MTHI, 32'd1, 32'd0);
      step(); issue(OP_MTHI, 32'd2, 32'd0);
      step(); issue(OP_MFHI, 32'd0, 32'd0); #1;
      check("mfhi_block2", {hilo_pending, req_ready}, {2'd2, 1'b0});
      step(); issue(OP_MFHI, 32'd0, 32'd0); wb_hilo_commit = 1'b1;
      step(); issue(OP_MFHI, 32'd0, 32'd0); wb_hilo_commit = 1'b1; #1;
      check("mfhi_block1", {hilo_pending, req_ready}, {2'd1, 1'b0});
      step(); issue(OP_MFHI, 32'd0, 32'd0); #1;
      check("mfhi_accept", {hilo_pending, req_ready}, {2'd0, 1'b1});
      step(); #1;
      check("mfhi_no_count", hilo_pending, 0);

      // Unsigned divide flushed while waiting, result drained silently.
      step(); issue(OP_DIVU, 32'hFFFF_FFF0, 32'd3);
      exp_send.push_back({1'b0, 32'hFFFF_FFF0, 32'd3});
      step(); div_s_ready = 1'b1;
      step(); flush = 1'b1; #1;
      check("flush_ready", req_ready, 0);
      step(); #1;
      check("drain_busy_pend", {busy, hilo_pending}, {1'b1, 2'd0});
      step(); div_p_valid = 1'b1; #1;
      check("drain_no_done", div_done, 0);
      step(); #1;
      check("drain_idle", busy, 0);

      // Flush coincident with the operand handshake.
      step(); issue(OP_DIV, 32'd20, 32'd4);
      exp_send.push_back({1'b1, 32'd20, 32'd4});
      step(); div_s_ready = 1'b1; flush = 1'b1;
      step(); #1;
      check("flush_send_drain", {busy, div_s_valid, hilo_pending}, {1'b1, 1'b0, 2'd0});
      step(); div_p_valid = 1'b1;
      step(); #1;
      check("flush_send_idle", busy, 0);

      // Flush in SEND without handshake goes straight back to idle.
      step(); issue(OP_DIVU, 32'd77, 32'd11);
      step(); flush = 1'b1; #1;
      check("flush_send_valid", div_s_valid, 1);
      void'(exp_send.size());
      exp_send.push_back({1'b0, 32'd77, 32'd11});
      step(); #1;
      check("flush_send_noshake", {busy, div_s_valid}, 2'b00);
      exp_send.delete();

      // Flush coincident with the result strobe.
      step(); issue(OP_DIV, 32'd30, 32'd6);
      exp_send.push_back({1'b1, 32'd30, 32'd6});
      step(); div_s_ready = 1'b1;
      step(); div_p_valid = 1'b1; flush = 1'b1; #1;
      check("flush_pvalid_done", div_done, 0);
      step(); #1;
      check("flush_pvalid_idle", busy, 0);

      // Reset in WAIT, then a stale result strobe.
      step(); issue(OP_DIV, 32'd55, 32'd5);
      exp_send.push_back({1'b1, 32'd55, 32'd5});
      step(); div_s_ready = 1'b1;
      step(); reset = 1'b1; div_p_valid = 1'b1; flush = 1'b1;
      step(); div_p_valid = 1'b1; #1;
      check("rst_wait_done", div_done, 0);
      check("rst_wait_state", {busy, div_s_valid, hilo_pending}, 0);
      check("rst_wait_operands", {div_signed, div_dividend, div_divisor}, 0);

      step(); step();
      check("send_queue_empty", exp_send.size(), 0);
      check("done_queue_empty", exp_done.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
